keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner for a ROWS x COLS keypad, with an integrated frame-level debouncer, single-key event policy, optional auto-repeat, and a key-event FIFO behind a valid/ready handshake. It drives the row lines, samples the column lines, and feeds key codes to the core-side consumer that handles input.

## Interface
- ROWS, 4, number of keypad rows (≥2).
- COLS, 4, number of keypad columns (≥2).
- SCAN_DIV, 50000, clock cycles per row slot (≥2).
- DEBOUNCE, 3, consecutive identical frames required to accept a frame (≥1).
- FIFO_DEPTH, 4, event FIFO entries (power of 2, ≥2).
- REPEAT_EN, 0, 1 enables auto-repeat.
- REPEAT_DELAY, 4, debounced frames before the first repeat (≥1).
- REPEAT_RATE, 2, debounced frames between subsequent repeats (≥1).
- clk  in  1  system clock; the block has one clock.
- reset  in  1  synchronous, active-low reset.
- col  in  COLS  column sense, active-low (0 = pressed in the driven row).
- row  out  ROWS  row drive, active-low one-hot.
- key  out  KW  head-of-FIFO key code, KW = clog2(ROWS*COLS), code = r*COLS + c.
- key_valid  out  1  FIFO non-empty.
- key_ready  in  1  consumer accepts; a pop occurs when key_valid & key_ready.
- pressed  out  1  debounced frame has ≥1 key down.
- overflow  out  1  one-cycle pulse when an event is dropped.

## Operation
- Scan: the row index r runs from 0 to ROWS-1. Each slot lasts SCAN_DIV cycles, with row = ~(1<<r).
  - col is sampled on the last cycle of each slot; this is the settling allowance.
  - Sampled bits (inverted col) are written into a ROWS*COLS raw frame.
  - The frame ends on the last cycle of slot ROWS-1.
- Debounce at frame end:
  - Counter cnt holds 1..DEBOUNCE.
  - If the new frame differs from the previous raw frame, cnt=1; otherwise cnt saturates at +1.
  - When cnt==DEBOUNCE, the debounced frame is loaded.
- Event FSM, evaluated once per frame end on the debounced frame, one cycle after it loads. States:
  - IDLE: exactly one key K → push K, enter HELD(K), rc=0. Two or more keys → BLOCKED. None → stay.
  - HELD: empty → IDLE. Single K and REPEAT_EN → rc++; at rc==REPEAT_DELAY push K, enter REPEAT, rc=0. Anything else (other key or multi-key) → BLOCKED.
  - REPEAT: single K → rc++; at rc==REPEAT_RATE push K, rc=0. Empty → IDLE. Other → BLOCKED.
  - BLOCKED: no events; exits to IDLE only when the debounced frame is empty. This is the ghost/rollover rejection.
- FIFO:
  - Push when not full. A push while full drops the new code and pulses overflow for 1 cycle.
  - Push and pop in the same cycle while full: the pop takes effect first, the push succeeds, no overflow.
  - Order is strictly FIFO. key is undefined-but-stable when key_valid=0 and is driven as 0 after reset.
- pressed = OR of the debounced frame.

## Timing
- Reset (reset=0 sampled at a clk edge) sets:
  - row=all ones, r=0, slot counter 0.
  - raw/previous/debounced frames empty, cnt=DEBOUNCE, FSM IDLE, rc=0.
  - FIFO empty, key=0, key_valid=0, pressed=0, overflow=0.
- First cycle after reset release: row = ~1.
- Frame period: ROWS*SCAN_DIV cycles.
- Press latency, with the key stable before a frame starts:
  - The debounced frame loads at end cycle E of the DEBOUNCE-th identical frame.
  - The FSM pushes at E+1.
  - key_valid rises at E+2.
- pressed updates at E+1.
- Reset asserted mid-operation discards queued events and any partial frame; there are no spurious events after release.
- key_ready is ignored while key_valid=0.

## Test plan
Bench parameters for all scenarios: ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=3, FIFO_DEPTH=4 (16-cycle frame).
- Hold row 2/col 1 pressed from reset, key_ready=1 → exactly one event key=9, valid 2 cycles after the 3rd frame end; release → pressed falls after 3 frames, no further event.
- Toggle the pressed state of key 6 every frame for 10 frames → no event, pressed stays 0.
- key_ready=0, press and release codes 1,2,3,4,5 in turn → 4 entries; overflow pulses once at the push of 5. Then key_ready=1 → pops 1,2,3,4 in order, and key_valid drops after the 4th pop.
- Press 0 and 5 together, then release 5 with 0 still held → BLOCKED, no events; release all, then press 3 → one event key=3.
- REPEAT_EN=1, REPEAT_DELAY=4, REPEAT_RATE=2, hold key 5 for 12 debounced frames after acceptance → 6 events key=5, at acceptance frames +0,+4,+6,+8,+10,+12.
- 2 entries queued, assert reset for 1 cycle → next cycle key_valid=0, row=all ones, overflow=0; no event after release until a new debounced press.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad row scanner with frame-level debounce, a single-key
// event policy (multi-key frames are blocked until all keys lift), optional
// auto-repeat and a valid/ready key-event FIFO.
module keypad_scanner #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE     = 3,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          REPEAT_EN    = 1'b0,
  parameter int unsigned REPEAT_DELAY = 4,
  parameter int unsigned REPEAT_RATE  = 2,
  localparam int unsigned KW          = $clog2(ROWS * COLS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [COLS-1:0] col_i,
  output logic [ROWS-1:0] row_o,
  output logic [KW-1:0]   key_o,
  output logic            key_valid_o,
  input  logic            key_ready_i,
  output logic            pressed_o,
  output logic            overflow_o
);

  localparam int unsigned N    = ROWS * COLS;
  localparam int unsigned DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned CW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RCW  = $clog2(RMAX + 1);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StHeld, StRepeat, StBlocked} state_e;

  logic          active_q;
  logic [DW-1:0] div_q, div_d;
  logic [RW-1:0] r_q, r_d;
  logic [N-1:0]  raw_q, raw_d, prev_q, prev_d, deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          eval_q;
  logic          slot_end, frame_end;

  state_e         state_q, state_d;
  logic [RCW-1:0] rc_q, rc_d;
  logic [KW-1:0]  held_q, held_d;
  logic           push;
  logic [KW-1:0]  push_key;
  logic [1:0]     nkeys;
  logic [KW-1:0]  one_idx;

  logic [FIFO_DEPTH-1:0][KW-1:0] mem_q;
  logic [AW:0]                   wptr_q, rptr_q;
  logic                          full, pop, push_ok, overflow_q;

  // Slot/frame boundaries and row drive; rows stay released until scanning starts.
  always_comb begin
    slot_end  = active_q && (div_q == DW'(SCAN_DIV - 1));
    frame_end = slot_end && (r_q == RW'(ROWS - 1));
    row_o     = active_q ? ~(ROWS'(1) << r_q) : '1;
  end

  // Next scan position, raw frame capture and frame-end debounce.
  always_comb begin
    div_d  = div_q;
    r_d    = r_q;
    raw_d  = raw_q;
    prev_d = prev_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (active_q) begin
      if (slot_end) begin
        div_d = '0;
        raw_d[int'(r_q) * COLS +: COLS] = ~col_i;
        r_d = (r_q == RW'(ROWS - 1)) ? '0 : r_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    if (frame_end) begin
      prev_d = raw_d;
      if (raw_d != prev_q) begin
        cnt_d = CW'(1);
      end else if (cnt_q != CW'(DEBOUNCE)) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CW'(DEBOUNCE)) begin
        deb_d = raw_d;
      end
    end
  end

  // Scan and debounce state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      div_q    <= '0;
      r_q      <= '0;
      raw_q    <= '0;
      prev_q   <= '0;
      deb_q    <= '0;
      cnt_q    <= CW'(DEBOUNCE);
      eval_q   <= 1'b0;
    end else begin
      active_q <= 1'b1;
      div_q    <= div_d;
      r_q      <= r_d;
      raw_q    <= raw_d;
      prev_q   <= prev_d;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      eval_q   <= frame_end;
    end
  end

  // Count debounced keys (saturating at 2) and locate the key when exactly one is down.
  always_comb begin
    nkeys   = 2'd0;
    one_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (deb_q[i]) begin
        one_idx = KW'(i);
        if (nkeys != 2'd2) nkeys = nkeys + 2'd1;
      end
    end
  end

  // Event policy, evaluated one cycle after each frame end.
  always_comb begin
    state_d  = state_q;
    rc_d     = rc_q;
    held_d   = held_q;
    push     = 1'b0;
    push_key = held_q;
    if (eval_q) begin
      unique case (state_q)
        StIdle: begin
          if (nkeys == 2'd1) begin
            push     = 1'b1;
            push_key = one_idx;
            held_d   = one_idx;
            rc_d     = '0;
            state_d  = StHeld;
          end else if (nkeys == 2'd2) begin
            state_d = StBlocked;
          end
        end
        StHeld: begin
          if (nkeys == 2'd0) begin
            state_d = StIdle;
          end else if (nkeys == 2'd1 && one_idx == held_q) begin
            if (REPEAT_EN) begin
              rc_d = rc_q + 1'b1;
              if (rc_d == RCW'(REPEAT_DELAY)) begin
                push    = 1'b1;
                rc_d    = '0;
                state_d = StRepeat;
              end
            end
          end else begin
            state_d = StBlocked;
          end
        end
        StRepeat: begin
          if (nkeys == 2'd0) begin
            state_d = StIdle;
          end else if (nkeys == 2'd1 && one_idx == held_q) begin
            rc_d = rc_q + 1'b1;
            if (rc_d == RCW'(REPEAT_RATE)) begin
              push = 1'b1;
              rc_d = '0;
            end
          end else begin
            state_d = StBlocked;
          end
        end
        StBlocked: begin
          if (nkeys == 2'd0) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Event FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rc_q    <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      held_q  <= held_d;
    end
  end

  // FIFO flags; a pop frees the slot for a same-cycle push when full.
  always_comb begin
    full        = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    key_valid_o = (wptr_q != rptr_q);
    pop         = key_valid_o && key_ready_i;
    push_ok     = push && (!full || pop);
    key_o       = mem_q[rptr_q[AW-1:0]];
    pressed_o   = |deb_q;
    overflow_o  = overflow_q;
  end

  // FIFO storage, pointers and the overflow pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= push_key;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      overflow_q <= push && full && !pop;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives col from row, a scoreboard queue
// holds expected key events and forked monitors pop/compare them on each handshake.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col, row, col2, row2, key, key2;
  logic        key_valid, key_ready, pressed, overflow;
  logic        key_valid2, key_ready2, pressed2, overflow2;
  logic [15:0] kp, kp2;

  int cyc   = -1;
  int total = 0;
  int bad   = 0;
  int n_pop = 0, n_ovf = 0, n_pop2 = 0;
  int exp_q[$];
  int exp2_q[$];
  int exp2_t[$];

  always #5 clk = ~clk;

  // Cycle index: 0 is the first cycle after reset release.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : -1;

  // Keypad model: a column reads low when a pressed key sits on a driven (low) row.
  always_comb begin
    col  = '1;
    col2 = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && kp[r*4+c])   col[c]  = 1'b0;
        if (!row2[r] && kp2[r*4+c]) col2[c] = 1'b0;
      end
    end
  end

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4),
    .REPEAT_EN(1'b0), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .col_i(col), .row_o(row), .key_o(key),
    .key_valid_o(key_valid), .key_ready_i(key_ready), .pressed_o(pressed),
    .overflow_o(overflow)
  );

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4),
    .REPEAT_EN(1'b1), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut_rep (
    .clk_i(clk), .rst_ni(rst_n), .col_i(col2), .row_o(row2), .key_o(key2),
    .key_valid_o(key_valid2), .key_ready_i(key_ready2), .pressed_o(pressed2),
    .overflow_o(overflow2)
  );

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    goto(0);
  endtask

  task automatic mon_main();
    int k;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1) begin
        n_pop++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL main_event: got key=%0d at cycle %0d, required no event", key, cyc);
        end else begin
          k = exp_q.pop_front();
          if (key !== 4'(k)) begin
            bad++;
            $display("FAIL main_key: got %0d at cycle %0d, required %0d", key, cyc, k);
          end
        end
      end
      if (rst_n === 1'b1 && overflow === 1'b1) n_ovf++;
    end
  endtask

  task automatic mon_rep();
    int k, t;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && key_valid2 === 1'b1 && key_ready2 === 1'b1) begin
        n_pop2++;
        total++;
        if (exp2_q.size() == 0) begin
          bad++;
          $display("FAIL rep_event: got key=%0d at cycle %0d, required no event", key2, cyc);
        end else begin
          k = exp2_q.pop_front();
          t = exp2_t.pop_front();
          if (key2 !== 4'(k) || cyc != t) begin
            bad++;
            $display("FAIL rep_key: got key=%0d cycle=%0d, required key=%0d cycle=%0d",
                     key2, cyc, k, t);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    kp = '0; kp2 = '0; key_ready = 1'b0; key_ready2 = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    total++; if (row !== 4'hF) begin bad++; $display("FAIL rst_row: got %h, required f", row); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", key_valid); end
    total++; if (key !== 4'h0) begin bad++; $display("FAIL rst_key: got %h, required 0", key); end
    total++; if (pressed !== 1'b0) begin bad++; $display("FAIL rst_pressed: got %b, required 0", pressed); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    rst_n = 1'b1;
    goto(0);
    total++; if (row !== 4'hE) begin bad++; $display("FAIL row_first: got %h, required e", row); end
    goto(3);
    total++; if (row !== 4'hE) begin bad++; $display("FAIL row_slot0_end: got %h, required e", row); end
    goto(4);
    total++; if (row !== 4'hD) begin bad++; $display("FAIL row_slot1: got %h, required d", row); end
  endtask

  task automatic test_single_press();
    int p0;
    kp = 16'h1 << 9; key_ready = 1'b1;
    apply_reset();
    p0 = n_pop;
    exp_q.push_back(9);
    goto(47);
    total++; if (pressed !== 1'b0) begin bad++; $display("FAIL press_early: pressed=%b, required 0", pressed); end
    goto(48);
    total++; if (pressed !== 1'b1) begin bad++; $display("FAIL press_rise: pressed=%b, required 1", pressed); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL valid_early: got %b, required 0", key_valid); end
    goto(49);
    total++; if (key_valid !== 1'b1 || key !== 4'd9) begin
      bad++; $display("FAIL valid_rise: valid=%b key=%0d, required 1/9", key_valid, key);
    end
    kp = '0;
    goto(50);
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL valid_fall: got %b, required 0", key_valid); end
    goto(95);
    total++; if (pressed !== 1'b1) begin bad++; $display("FAIL release_early: pressed=%b, required 1", pressed); end
    goto(96);
    total++; if (pressed !== 1'b0) begin bad++; $display("FAIL release: pressed=%b, required 0", pressed); end
    goto(160);
    total++; if (n_pop - p0 != 1) begin bad++; $display("FAIL single_count: got %0d events, required 1", n_pop - p0); end
  endtask

  task automatic test_bounce();
    int p0;
    kp = '0; key_ready = 1'b1;
    apply_reset();
    p0 = n_pop;
    for (int k = 0; k < 10; k++) begin
      goto(16 * k);
      kp = (k % 2 == 0) ? (16'h1 << 6) : 16'h0;
      goto(16 * k + 15);
      total++; if (pressed !== 1'b0) begin
        bad++; $display("FAIL bounce_pressed: frame %0d pressed=%b, required 0", k, pressed);
      end
    end
    kp = '0;
    goto(16 * 14);
    total++; if (n_pop != p0 || key_valid !== 1'b0) begin
      bad++; $display("FAIL bounce_events: got %0d events valid=%b, required 0/0", n_pop - p0, key_valid);
    end
  endtask

  task automatic test_fifo_overflow();
    int p0, o0, base;
    kp = '0; key_ready = 1'b0;
    apply_reset();
    p0 = n_pop; o0 = n_ovf;
    for (int i = 1; i <= 5; i++) begin
      base = (i - 1) * 128;
      goto(base);
      kp = 16'h1 << i;
      if (i <= 4) exp_q.push_back(i);
      goto(base + 64);
      kp = '0;
      goto(base + 128);
      if (i == 4) begin
        total++; if (n_ovf != o0 || key_valid !== 1'b1 || key !== 4'd1) begin
          bad++; $display("FAIL fifo_fill: ovf=%0d valid=%b key=%0d, required 0/1/1", n_ovf - o0, key_valid, key);
        end
      end
    end
    total++; if (n_ovf - o0 != 1) begin bad++; $display("FAIL overflow_count: got %0d, required 1", n_ovf - o0); end
    total++; if (n_pop != p0) begin bad++; $display("FAIL pop_while_not_ready: got %0d, required 0", n_pop - p0); end
    key_ready = 1'b1;
    goto(643);
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL drain_last: valid=%b, required 1", key_valid); end
    goto(644);
    total++; if (key_valid !== 1'b0 || n_pop - p0 != 4 || exp_q.size() != 0) begin
      bad++; $display("FAIL drain: valid=%b pops=%0d pending=%0d, required 0/4/0",
                      key_valid, n_pop - p0, exp_q.size());
    end
  endtask

  task automatic test_ghost();
    int p0;
    kp = '0; key_ready = 1'b1;
    apply_reset();
    p0 = n_pop;
    kp = 16'h0021;
    goto(64);
    total++; if (pressed !== 1'b1) begin bad++; $display("FAIL ghost_pressed: got %b, required 1", pressed); end
    kp = 16'h0001;
    goto(128);
    total++; if (pressed !== 1'b1 || n_pop != p0) begin
      bad++; $display("FAIL blocked: pressed=%b events=%0d, required 1/0", pressed, n_pop - p0);
    end
    kp = '0;
    goto(192);
    total++; if (pressed !== 1'b0) begin bad++; $display("FAIL blocked_release: pressed=%b, required 0", pressed); end
    kp = 16'h1 << 3;
    exp_q.push_back(3);
    goto(256);
    kp = '0;
    goto(320);
    total++; if (n_pop - p0 != 1) begin bad++; $display("FAIL ghost_count: got %0d events, required 1", n_pop - p0); end
  endtask

  task automatic test_repeat();
    int p0;
    int offs[6] = '{0, 4, 6, 8, 10, 12};
    kp = '0; kp2 = 16'h1 << 5; key_ready2 = 1'b1;
    apply_reset();
    p0 = n_pop2;
    // Acceptance is frame 3; frame j ends at cycle 16j-1 and the handshake lands 2 cycles later.
    foreach (offs[j]) begin
      exp2_q.push_back(5);
      exp2_t.push_back(16 * (3 + offs[j]) + 1);
    end
    goto(224);
    kp2 = '0;
    goto(400);
    total++; if (n_pop2 - p0 != 6 || exp2_q.size() != 0) begin
      bad++; $display("FAIL repeat_count: got %0d events pending=%0d, required 6/0", n_pop2 - p0, exp2_q.size());
    end
    key_ready2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int p0;
    kp = '0; key_ready = 1'b0;
    apply_reset();
    kp = 16'h1 << 7;
    goto(64);  kp = '0;
    goto(128); kp = 16'h1 << 8;
    goto(192); kp = '0;
    goto(256);
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL queued: valid=%b, required 1", key_valid); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++; if (key_valid !== 1'b0 || row !== 4'hF || overflow !== 1'b0) begin
      bad++; $display("FAIL mid_reset: valid=%b row=%h ovf=%b, required 0/f/0", key_valid, row, overflow);
    end
    rst_n = 1'b1;
    goto(0);
    p0 = n_pop;
    key_ready = 1'b1;
    goto(128);
    total++; if (n_pop != p0 || key_valid !== 1'b0) begin
      bad++; $display("FAIL spurious: events=%0d valid=%b, required 0/0", n_pop - p0, key_valid);
    end
    kp = 16'h1 << 2;
    exp_q.push_back(2);
    goto(192);
    kp = '0;
    goto(256);
    total++; if (n_pop - p0 != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL post_reset_press: events=%0d pending=%0d, required 1/0", n_pop - p0, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    kp = '0; kp2 = '0; key_ready = 1'b0; key_ready2 = 1'b0;
    fork
      mon_main();
      mon_rep();
      begin
        #500000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1);
      end
    join_none
    test_reset();
    test_single_press();
    test_bounce();
    test_fifo_overflow();
    test_ghost();
    test_repeat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
